fx2_slave_fifo_emu: RTL and testbench

Synthesizable emulator of the FX2 slave-FIFO end of the CY_* bus. It is the responder that the FPGA-side FX2 master drives. It provides an EP2 OUT FIFO, which the host side fills and the master reads over SLRD/SLOE, and an EP6 IN FIFO, which the master writes over SLWR/PKTEND and the host side drains packet by packet. It is used for loopback benches and FPGA self-test without the USB chip. All logic runs on the interface clock.

---
 rtl/fx2_slave_fifo_emu.sv | 183 ++++++++++++++++++
 tb/tb_fx2_slave_fifo_emu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_slave_fifo_emu.sv
// FX2 slave-FIFO responder: EP2 OUT FIFO (host -> master, FWFT on CY_DATA) and
// EP6 IN FIFO (master -> host, packetised by word count or PKTEND).
module fx2_slave_fifo_emu #(
    parameter int EP2_AW        = 9,
    parameter int EP6_AW        = 9,
    parameter int EP6_PKT_WORDS = 256
) (
    input  logic        REF_CLK_180,
    input  logic        RST_N,
    inout  logic [15:0] CY_DATA,
    input  logic [1:0]  CY_ADDR,
    input  logic        CY_SLRD_N,
    input  logic        CY_SLWR_N,
    input  logic        CY_PKTEND,
    input  logic        CY_SLOE_N,
    output logic        CY_FLAGA,
    output logic        CY_FLAGB,
    input  logic [15:0] HOST_WR_DATA,
    input  logic        HOST_WR_VALID,
    output logic        HOST_WR_READY,
    output logic [15:0] HOST_RD_DATA,
    output logic        HOST_RD_VALID,
    output logic        HOST_RD_LAST,
    input  logic        HOST_RD_READY,
    output logic [7:0]  EP6_PKT_COUNT,
    output logic        ERR_OVERFLOW,
    output logic        ERR_UNDERFLOW,
    output logic        ERR_CONTENTION
);

    localparam int SW = $clog2(EP6_PKT_WORDS + 1);
    localparam logic [SW-1:0] PKT_W = SW'(EP6_PKT_WORDS);

    logic [15:0]     r_ep2_mem [0:(1<<EP2_AW)-1];
    logic [EP2_AW:0] r_ep2_wr;
    logic [EP2_AW:0] r_ep2_rd;
    logic [EP2_AW:0] w_ep2_wr_nxt;
    logic [EP2_AW:0] w_ep2_rd_nxt;
    logic            w_ep2_empty;
    logic            w_ep2_full;
    logic            w_ep2_push;
    logic            w_ep2_rd_req;
    logic            w_ep2_pop;
    logic [15:0]     w_ep2_head;
    logic            w_cy_oe;

    logic [16:0]     r_ep6_mem [0:(1<<EP6_AW)-1];
    logic [EP6_AW:0] r_ep6_wr;
    logic [EP6_AW:0] r_ep6_cmt;
    logic [EP6_AW:0] r_ep6_rd;
    logic [EP6_AW:0] w_ep6_wr_nxt;
    logic [EP6_AW:0] w_ep6_rd_nxt;
    logic [EP6_AW-1:0] w_ep6_prev_idx;
    logic [SW-1:0]   r_stage;
    logic [SW-1:0]   w_stage_inc;
    logic [7:0]      r_pkt_cnt;
    logic            w_ep6_full;
    logic            w_ep6_wr_req;
    logic            w_ep6_wr;
    logic            w_pe_req;
    logic            w_auto;
    logic            w_pe_mark;
    logic            w_commit;
    logic            w_host_pop;
    logic [16:0]     w_ep6_head;

    logic            r_flaga;
    logic            r_flagb;
    logic            r_err_ovf;
    logic            r_err_unf;
    logic            r_err_cont;
    logic            w_sel_ep2;
    logic            w_sel_ep6;

    assign w_sel_ep2 = (CY_ADDR == 2'b00);
    assign w_sel_ep6 = (CY_ADDR == 2'b10);

    // EP2 OUT: host pushes, master pops over SLRD
    assign w_ep2_empty  = (r_ep2_wr == r_ep2_rd);
    assign w_ep2_full   = (r_ep2_wr[EP2_AW] != r_ep2_rd[EP2_AW]) &&
                          (r_ep2_wr[EP2_AW-1:0] == r_ep2_rd[EP2_AW-1:0]);
    assign w_ep2_push   = HOST_WR_VALID && !w_ep2_full;
    assign w_ep2_rd_req = !CY_SLRD_N && w_sel_ep2;
    assign w_ep2_pop    = w_ep2_rd_req && !w_ep2_empty;
    assign w_ep2_wr_nxt = r_ep2_wr + (EP2_AW+1)'(w_ep2_push);
    assign w_ep2_rd_nxt = r_ep2_rd + (EP2_AW+1)'(w_ep2_pop);
    assign w_ep2_head   = r_ep2_mem[r_ep2_rd[EP2_AW-1:0]];
    assign HOST_WR_READY = !w_ep2_full;

    // Bus is released whenever the master is writing, even if SLOE_N is also low
    assign w_cy_oe = !CY_SLOE_N && w_sel_ep2 && CY_SLWR_N;
    assign CY_DATA = w_cy_oe ? w_ep2_head : 'z;

    always_ff @(posedge REF_CLK_180) begin
        if (w_ep2_push) begin
            r_ep2_mem[r_ep2_wr[EP2_AW-1:0]] <= HOST_WR_DATA;
        end
    end

    always_ff @(posedge REF_CLK_180 or negedge RST_N) begin
        if (!RST_N) begin
            r_ep2_wr <= '0;
            r_ep2_rd <= '0;
            r_flaga  <= 1'b0;
        end else begin
            r_ep2_wr <= w_ep2_wr_nxt;
            r_ep2_rd <= w_ep2_rd_nxt;
            r_flaga  <= (w_ep2_wr_nxt != w_ep2_rd_nxt);
        end
    end

    // EP6 IN: master writes, commit pointer gates host visibility
    assign w_ep6_full     = (r_ep6_wr[EP6_AW] != r_ep6_rd[EP6_AW]) &&
                            (r_ep6_wr[EP6_AW-1:0] == r_ep6_rd[EP6_AW-1:0]);
    assign w_ep6_wr_req   = !CY_SLWR_N && w_sel_ep6;
    assign w_ep6_wr       = w_ep6_wr_req && !w_ep6_full;
    assign w_pe_req       = !CY_PKTEND && w_sel_ep6;
    assign w_stage_inc    = r_stage + SW'(1);
    assign w_auto         = w_ep6_wr && (w_stage_inc == PKT_W);
    // PKTEND without an accepted word retro-marks the last staged entry
    assign w_pe_mark      = w_pe_req && !w_ep6_wr && (r_stage != '0);
    assign w_commit       = w_auto || (w_pe_req && w_ep6_wr) || w_pe_mark;
    assign w_ep6_wr_nxt   = r_ep6_wr + (EP6_AW+1)'(w_ep6_wr);
    assign w_ep6_prev_idx = r_ep6_wr[EP6_AW-1:0] - EP6_AW'(1);

    assign HOST_RD_VALID  = (r_ep6_rd != r_ep6_cmt);
    assign w_host_pop     = HOST_RD_VALID && HOST_RD_READY;
    assign w_ep6_rd_nxt   = r_ep6_rd + (EP6_AW+1)'(w_host_pop);
    assign w_ep6_head     = r_ep6_mem[r_ep6_rd[EP6_AW-1:0]];
    assign HOST_RD_DATA   = w_ep6_head[15:0];
    assign HOST_RD_LAST   = HOST_RD_VALID && w_ep6_head[16];

    always_ff @(posedge REF_CLK_180) begin
        if (w_ep6_wr) begin
            r_ep6_mem[r_ep6_wr[EP6_AW-1:0]] <= {w_auto || w_pe_req, CY_DATA};
        end else if (w_pe_mark) begin
            r_ep6_mem[w_ep6_prev_idx][16] <= 1'b1;
        end
    end

    always_ff @(posedge REF_CLK_180 or negedge RST_N) begin
        if (!RST_N) begin
            r_ep6_wr  <= '0;
            r_ep6_cmt <= '0;
            r_ep6_rd  <= '0;
            r_stage   <= '0;
            r_pkt_cnt <= '0;
            r_flagb   <= 1'b1;
        end else begin
            r_ep6_wr  <= w_ep6_wr_nxt;
            r_ep6_rd  <= w_ep6_rd_nxt;
            r_flagb   <= !((w_ep6_wr_nxt[EP6_AW] != w_ep6_rd_nxt[EP6_AW]) &&
                           (w_ep6_wr_nxt[EP6_AW-1:0] == w_ep6_rd_nxt[EP6_AW-1:0]));
            if (w_commit) begin
                r_ep6_cmt <= w_ep6_wr_nxt;
                r_stage   <= '0;
                r_pkt_cnt <= r_pkt_cnt + 8'd1;
            end else if (w_ep6_wr) begin
                r_stage   <= w_stage_inc;
            end
        end
    end

    always_ff @(posedge REF_CLK_180 or negedge RST_N) begin
        if (!RST_N) begin
            r_err_ovf  <= 1'b0;
            r_err_unf  <= 1'b0;
            r_err_cont <= 1'b0;
        end else begin
            if (w_ep6_wr_req && w_ep6_full)  r_err_ovf  <= 1'b1;
            if (w_ep2_rd_req && w_ep2_empty) r_err_unf  <= 1'b1;
            if (!CY_SLOE_N && !CY_SLWR_N)    r_err_cont <= 1'b1;
        end
    end

    assign CY_FLAGA       = r_flaga;
    assign CY_FLAGB       = r_flagb;
    assign EP6_PKT_COUNT  = r_pkt_cnt;
    assign ERR_OVERFLOW   = r_err_ovf;
    assign ERR_UNDERFLOW  = r_err_unf;
    assign ERR_CONTENTION = r_err_cont;

endmodule

// File: tb/tb_fx2_slave_fifo_emu.sv
// Bench for fx2_slave_fifo_emu: directed scenarios plus random traffic, all
// checked every cycle against a queue-based packet model.
module tb_fx2_slave_fifo_emu;

    logic        clk;
    logic        rst_n;
    logic [1:0]  addr;
    logic        slrd_n, slwr_n, pktend_n, sloe_n;
    logic        hwv, hrr;
    logic [15:0] hwd, wdata;
    logic        flaga, flagb, hwr_ready, hrd_valid, hrd_last;
    logic [15:0] hrd_data;
    logic [7:0]  pkt_count;
    logic        err_ovf, err_unf, err_cont;
    wire  [15:0] cy_data;

    // Master drives the bus only while writing with its output enable off
    assign cy_data = (!slwr_n && sloe_n) ? wdata : 'z;
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup pu (cy_data[g]);
    end

    fx2_slave_fifo_emu #(.EP2_AW(9), .EP6_AW(9), .EP6_PKT_WORDS(256)) dut (
        .REF_CLK_180   (clk),
        .RST_N         (rst_n),
        .CY_DATA       (cy_data),
        .CY_ADDR       (addr),
        .CY_SLRD_N     (slrd_n),
        .CY_SLWR_N     (slwr_n),
        .CY_PKTEND     (pktend_n),
        .CY_SLOE_N     (sloe_n),
        .CY_FLAGA      (flaga),
        .CY_FLAGB      (flagb),
        .HOST_WR_DATA  (hwd),
        .HOST_WR_VALID (hwv),
        .HOST_WR_READY (hwr_ready),
        .HOST_RD_DATA  (hrd_data),
        .HOST_RD_VALID (hrd_valid),
        .HOST_RD_LAST  (hrd_last),
        .HOST_RD_READY (hrr),
        .EP6_PKT_COUNT (pkt_count),
        .ERR_OVERFLOW  (err_ovf),
        .ERR_UNDERFLOW (err_unf),
        .ERR_CONTENTION(err_cont)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [15:0] m_ep2[$];
    logic [16:0] m_com[$];
    logic [16:0] m_stg[$];
    int unsigned m_pkt;
    bit          m_ovf, m_unf, m_cont;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        addr = 2'b00; slrd_n = 1'b1; slwr_n = 1'b1; pktend_n = 1'b1; sloe_n = 1'b1;
        hwv = 1'b0; hrr = 1'b0; hwd = '0; wdata = '0;
    endtask

    task automatic model_clear();
        m_ep2.delete(); m_com.delete(); m_stg.delete();
        m_pkt = 0; m_ovf = 0; m_unf = 0; m_cont = 0;
    endtask

    task automatic compare();
        bit dut_oe;
        dut_oe = !sloe_n && addr == 2'b00 && slwr_n;
        chk("flaga", flaga, m_ep2.size() != 0);
        chk("flagb", flagb, (m_com.size() + m_stg.size()) != 512);
        chk("wr_ready", hwr_ready, m_ep2.size() < 512);
        chk("rd_valid", hrd_valid, m_com.size() != 0);
        if (m_com.size() != 0) chk("rd_head", {hrd_last, hrd_data}, m_com[0]);
        else                   chk("rd_last", hrd_last, 0);
        chk("pkt_count", pkt_count, m_pkt % 256);
        chk("errors", {err_ovf, err_unf, err_cont}, {m_ovf, m_unf, m_cont});
        if (dut_oe && m_ep2.size() != 0) chk("cy_data", cy_data, m_ep2[0]);
        else if (!dut_oe && !(!slwr_n && sloe_n)) chk("cy_data_z", cy_data, 16'hFFFF);
    endtask

    task automatic commit_staged();
        logic [16:0] t;
        t = m_stg.pop_back();
        t[16] = 1'b1;
        m_stg.push_back(t);
        while (m_stg.size() != 0) m_com.push_back(m_stg.pop_front());
        m_pkt++;
    endtask

    task automatic model_edge();
        int unsigned total;
        bit rd_req, wr_req, pe, wrote;
        logic [15:0] bus;
        total  = m_com.size() + m_stg.size();
        rd_req = addr == 2'b00 && !slrd_n;
        wr_req = addr == 2'b10 && !slwr_n;
        pe     = addr == 2'b10 && !pktend_n;
        bus    = (!slwr_n && sloe_n) ? wdata : 16'hFFFF;
        wrote  = 0;
        if (!sloe_n && !slwr_n) m_cont = 1;
        if (rd_req) begin
            if (m_ep2.size() == 0) m_unf = 1;
            else void'(m_ep2.pop_front());
        end
        if (hwv && m_ep2.size() < 512 + (rd_req ? 0 : 0)) begin
            // push legality uses the pre-edge count
        end
        if (hrr && m_com.size() != 0) void'(m_com.pop_front());
        if (wr_req) begin
            if (total == 512) m_ovf = 1;
            else begin m_stg.push_back({1'b0, bus}); wrote = 1; end
        end
        if (wrote && (m_stg.size() == 256 || pe)) commit_staged();
        else if (!wrote && pe && m_stg.size() != 0) commit_staged();
    endtask

    // One cycle: inputs already set at the falling edge
    task automatic step();
        bit push_ok;
        #1;
        compare();
        push_ok = hwv && m_ep2.size() < 512;
        model_edge();
        if (push_ok) m_ep2.push_back(hwd);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        model_clear();
        compare();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] words[4];
        int unsigned nread;
        words[0] = 16'h4551; words[1] = 16'h4652; words[2] = 16'h1234; words[3] = 16'h5678;
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();
        step();

        // EP2 push four words, then drain them over SLRD with SLOE
        for (int i = 0; i < 4; i++) begin hwv = 1'b1; hwd = words[i]; step(); end
        idle();
        sloe_n = 1'b0; slrd_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("ep2_word", cy_data, words[i]);
            step();
        end
        idle(); #1 chk("flaga_fell", flaga, 0);
        step();

        // Exactly one full packet; trailing PKTEND must not add another
        do_reset();
        for (int i = 0; i < 256; i++) begin addr = 2'b10; slwr_n = 1'b0; wdata = 16'(i); step(); end
        idle(); addr = 2'b10; pktend_n = 1'b0; step();
        idle(); #1 chk("pkt_full", pkt_count, 1);
        hrr = 1'b1;
        for (int i = 0; i < 256; i++) step();
        idle(); #1 chk("full_pkt_drained", hrd_valid, 0);
        step();

        // Short packet invisible until PKTEND
        do_reset();
        for (int i = 0; i < 10; i++) begin addr = 2'b10; slwr_n = 1'b0; wdata = 16'hA000 + 16'(i); step(); end
        idle(); #1 chk("short_hidden", hrd_valid, 0);
        addr = 2'b10; pktend_n = 1'b0; step();
        idle(); #1 chk("pkt_short", pkt_count, 1);
        hrr = 1'b1;
        for (int i = 0; i < 10; i++) step();
        idle(); step();

        // Fill EP6, overflow one word, then count what the host gets
        do_reset();
        for (int i = 0; i < 513; i++) begin addr = 2'b10; slwr_n = 1'b0; wdata = 16'h3000 + 16'(i); step(); end
        idle(); #1 chk("ovf_flag", err_ovf, 1);
        chk("flagb_full", flagb, 0);
        hrr = 1'b1; nread = 0;
        for (int i = 0; i < 530; i++) begin
            #1 if (hrd_valid) nread++;
            step();
        end
        idle(); chk("ovf_words", nread, 512);
        step();

        // Underflow, contention, and reset mid-packet
        do_reset();
        addr = 2'b00; slrd_n = 1'b0; step();
        idle(); hwv = 1'b1; hwd = 16'h1357; step();
        idle(); sloe_n = 1'b0; #1 chk("unf_ptr_kept", cy_data, 16'h1357);
        step();
        idle(); sloe_n = 1'b0; slwr_n = 1'b0; #1 chk("cont_z", cy_data, 16'hFFFF);
        step();
        idle(); #1 chk("cont_err", err_cont, 1);
        for (int i = 0; i < 5; i++) begin addr = 2'b10; slwr_n = 1'b0; wdata = 16'hBEEF; step(); end
        do_reset();
        step();

        // Random traffic with phased consumer/producer rates
        for (int seg = 0; seg < 8; seg++) begin
            int unsigned prd, cns;
            prd = $urandom_range(20, 95);
            cns = $urandom_range(5, 95);
            for (int i = 0; i < 500; i++) begin
                int unsigned r;
                idle();
                r = $urandom_range(0, 99);
                addr = (r < 35) ? 2'b00 : (r < 85) ? 2'b10 : ((r & 1) != 0) ? 2'b01 : 2'b11;
                sloe_n   = $urandom_range(0, 99) < 40;
                slwr_n   = sloe_n ? ($urandom_range(0, 99) >= prd) : 1'b1;
                slrd_n   = $urandom_range(0, 99) >= cns;
                pktend_n = $urandom_range(0, 99) >= 4;
                hwv      = $urandom_range(0, 99) < prd;
                hwd      = 16'($urandom);
                hrr      = $urandom_range(0, 99) < cns;
                wdata    = 16'($urandom);
                step();
            end
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
